// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O window at 0xFFF0-0xFFFF.
package mmio_pkg;

    localparam logic [11:0] MMIO_BASE     = 12'hFFF;
    localparam logic [15:0] MMIO_MISS_VAL = 16'hDEAD;

    localparam logic [3:0] MMIO_KEYS    = 4'h0;
    localparam logic [3:0] MMIO_SW      = 4'h2;
    localparam logic [3:0] MMIO_KEYEDGE = 4'h4;
    localparam logic [3:0] MMIO_TIMER   = 4'h6;
    localparam logic [3:0] MMIO_HEX     = 4'h8;
    localparam logic [3:0] MMIO_LEDR    = 4'hA;
    localparam logic [3:0] MMIO_LEDG    = 4'hC;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, stability counter, debounced level
// and a single-cycle pulse on the accepted press (1->0) transition.
module key_debounce
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_db,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_reg;
    logic          sync_reg;
    logic          db_reg;
    logic [CW-1:0] cnt_reg;
    logic          differ;
    logic          accept;

    assign differ = (sync_reg != db_reg);
    assign accept = differ && (cnt_reg == CNT_LAST);
    // Pulse coincides with the edge that updates db_reg, so the sticky
    // capture in the parent sets on the same clock.
    assign press  = accept && !sync_reg;
    assign key_db = db_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            db_reg   <= 1'b1;
            cnt_reg  <= '0;
        end else begin
            meta_reg <= key_raw;
            sync_reg <= meta_reg;
            if (!differ) begin
                cnt_reg <= '0;
            end else if (accept) begin
                db_reg  <= sync_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O stage: display/LED registers, debounced keys with sticky
// press capture, synchronised switches and a free-running millisecond timer.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int DBITS           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 50000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    output logic [DBITS-1:0] DOUT,
    output logic             HIT,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEXOUT,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    localparam int PW = cnt_width(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    logic [3:0]       offset;
    logic             wr;
    logic [3:0]       key_db;
    logic [3:0]       key_press;
    logic [3:0]       keyedge_reg;
    logic [3:0]       keyedge_next;
    logic [3:0]       edge_clr;
    logic [9:0]       sw_meta_reg;
    logic [9:0]       sw_sync_reg;
    logic [PW-1:0]    presc_reg;
    logic [DBITS-1:0] timer_reg;
    logic             tick;
    logic [15:0]      hex_reg;
    logic [9:0]       ledr_reg;
    logic [7:0]       ledg_reg;
    logic [15:0]      rd_val;

    assign HIT    = (ADDR[15:4] == MMIO_BASE);
    assign offset = ADDR[3:0];
    assign wr     = WE && HIT;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk    (CLK),
            .rst_n  (RESET_N),
            .key_raw(KEY[gi]),
            .key_db (key_db[gi]),
            .press  (key_press[gi])
        );
    end

    // A press landing on the same edge as its clear keeps the bit set.
    assign edge_clr     = (wr && offset == MMIO_KEYEDGE) ? DIN[3:0] : 4'h0;
    assign keyedge_next = (keyedge_reg & ~edge_clr) | key_press;
    assign tick         = (presc_reg == PRESC_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            keyedge_reg <= '0;
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            presc_reg   <= '0;
            timer_reg   <= '0;
            hex_reg     <= '0;
            ledr_reg    <= '0;
            ledg_reg    <= '0;
        end else begin
            keyedge_reg <= keyedge_next;
            sw_meta_reg <= SW;
            sw_sync_reg <= sw_meta_reg;

            // A timer load restarts the prescaler and swallows a coincident tick.
            if (wr && offset == MMIO_TIMER) begin
                timer_reg <= DIN;
                presc_reg <= '0;
            end else if (tick) begin
                timer_reg <= timer_reg + 1'b1;
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end

            if (wr && offset == MMIO_HEX)  hex_reg  <= DIN[15:0];
            if (wr && offset == MMIO_LEDR) ledr_reg <= DIN[9:0];
            if (wr && offset == MMIO_LEDG) ledg_reg <= DIN[7:0];
        end
    end

    always_comb begin
        rd_val = MMIO_MISS_VAL;
        if (HIT) begin
            case (offset)
                MMIO_KEYS:    rd_val = {12'h000, key_db};
                MMIO_SW:      rd_val = {6'b0, sw_sync_reg};
                MMIO_KEYEDGE: rd_val = {12'h000, keyedge_reg};
                MMIO_TIMER:   rd_val = timer_reg[15:0];
                MMIO_HEX:     rd_val = hex_reg;
                MMIO_LEDR:    rd_val = {6'b0, ledr_reg};
                MMIO_LEDG:    rd_val = {8'h00, ledg_reg};
                default:      rd_val = MMIO_MISS_VAL;
            endcase
        end
    end

    assign DOUT   = DBITS'(rd_val);
    assign HEXOUT = hex_reg;
    assign LEDR   = ledr_reg;
    assign LEDG   = ledg_reg;

endmodule
